bcd_serial_add_ctrl: RTL and testbench



---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state type for the digit-serial BCD adder.
// Imported by the controller and the single-digit adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bcd_ctrl_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary sum plus 6 when it passes 9.
// Purely combinational; out-of-range digits still follow the same rule.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] da,
  input  logic [3:0] db,
  input  logic       cin,
  output logic [3:0] dsum,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, da} + {1'b0, db} + {4'b0, cin};
    dsum = t[3:0];
    cout = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      dsum = t[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first.
// Operands and results move on separate valid/ready handshakes.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4*DIGITS-1:0]       a,
  input  logic [4*DIGITS-1:0]       b,
  input  logic                      carry_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*DIGITS-1:0]       sum,
  output logic                      carry_out,
  output logic                      digit_err,
  output logic                      busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  bcd_ctrl_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic [4*DIGITS-1:0] sum_q, sum_d;
  logic cout_q, cout_d;
  logic err_q, err_d;
  logic ov_q, ov_d;

  logic [3:0] da, db, dsum;
  logic dcout;

  assign da = a_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
  assign db = b_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];

  bcd_digit_add u_digit (
    .da   (da),
    .db   (db),
    .cin  (carry_q),
    .dsum (dsum),
    .cout (dcout)
  );

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    cout_d = cout_q;
    err_d = err_q;
    ov_d = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          carry_d = carry_in;
          err_d = 1'b0;
          idx_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W] = dsum;
        carry_d = dcout;
        err_d = err_q | (da > BCD_MAX) | (db > BCD_MAX);
        if (idx_q == LAST) begin
          cout_d = dcout;
          ov_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      err_q <= err_d;
      ov_q <= ov_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign out_valid = ov_q;
  assign sum = sum_q;
  assign carry_out = cout_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for the digit-serial BCD adder, DIGITS=4.
// Expected sums are worked out by hand per digit.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic carry_in;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] sum;
  logic carry_out;
  logic digit_err;
  logic busy;

  int n_run;
  int n_fail;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .digit_err (digit_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch one operation, wait for out_valid, check result fields.
  task automatic run_op(input string tag,
                        input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es,
                        input logic eco, input logic eerr);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    carry_in = tc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;
    carry_in = 1'b1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(DIGITS));
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_co"}, 64'(carry_out), 64'(eco));
    check({tag, "_err"}, 64'(digit_err), 64'(eerr));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_ov0"}, 64'(out_valid), 64'd0);
      check({tag, "_idle"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    int gap;
    int lat2;
    logic got1;
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    carry_in = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(carry_out), 64'd0);
    check("rst_err", 64'(digit_err), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("add2", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add3", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("bad", 16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b1);
    run_op("add5", 16'h4587, 16'h5413, 1'b1, 16'h0001, 1'b1, 1'b0);

    // Result must hold under backpressure.
    out_ready = 1'b0;
    run_op("bp", 16'h0999, 16'h0002, 1'b0, 16'h1001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(sum), 64'h1001);
      check("bp_co", 64'(carry_out), 64'd0);
      check("bp_rdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ov0", 64'(out_valid), 64'd0);
    check("bp_idle", 64'(in_ready), 64'd1);
    check("bp_hold", 64'(sum), 64'h1001);

    // Asynchronous reset two cycles into ADD.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h5555;
    b = 16'h5555;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rdy", 64'(in_ready), 64'd1);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_ov", 64'(out_valid), 64'd0);
    check("ar_sum", 64'(sum), 64'd0);
    check("ar_co", 64'(carry_out), 64'd0);
    check("ar_err", 64'(digit_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Back-to-back: in_valid held high across two operations.
    @(negedge clk);
    check("b2b_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = 16'h2222;
    b = 16'h7788;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    a = 16'h0050;
    b = 16'h0050;
    carry_in = 1'b0;
    gap = -1;
    got1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && !got1) begin
        got1 = 1'b1;
        check("b2b_s1", 64'(sum), 64'h0010);
        check("b2b_c1", 64'(carry_out), 64'd1);
      end
      if (in_ready) begin
        @(posedge clk);
        gap = i + 1;
        break;
      end
    end
    check("b2b_got1", 64'(got1), 64'd1);
    check("b2b_gap", 64'(gap), 64'(DIGITS + 2));
    #1;
    in_valid = 1'b0;
    lat2 = 0;
    while (!out_valid && lat2 < 20) begin
      @(posedge clk);
      #1;
      lat2++;
    end
    check("b2b_lat", 64'(lat2), 64'(DIGITS));
    check("b2b_s2", 64'(sum), 64'h0100);
    check("b2b_c2", 64'(carry_out), 64'd0);
    check("b2b_e2", 64'(digit_err), 64'd0);
    @(posedge clk);
    #1;
    check("b2b_end", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
